// File: rtl/hub_slot_sched_if.sv
// Hub slot scheduler bundle: mode/enable inputs from the hub, bus strobe and
// cog select outputs toward the hub and every cog.
interface hub_slot_sched_if #(
  parameter int NUMCOGS = 8
) ();
  logic               skip_idle;
  logic [NUMCOGS-1:0] cog_ena;
  logic               ena_bus;
  logic [NUMCOGS-1:0] bus_sel;
  logic [3:0]         slot_idx;
  logic               slot_valid;
  logic               slot_start;
  logic               wrap;

  // master: the scheduler; slave: hub/cog side consuming the select
  modport master (
    input  skip_idle, cog_ena,
    output ena_bus, bus_sel, slot_idx, slot_valid, slot_start, wrap
  );

  modport slave (
    output skip_idle, cog_ena,
    input  ena_bus, bus_sel, slot_idx, slot_valid, slot_start, wrap
  );
endinterface

// File: rtl/hub_slot_sched.sv
// Hub time-slot scheduler: NUMCOGS slots of SLOT_CYCLES clocks, fixed rotation
// or rotation restricted to enabled cogs, with one-hot select and wrap marker.
module hub_slot_sched #(
  parameter int NUMCOGS     = 8,
  parameter int SLOT_CYCLES = 2
) (
  input  logic             clk_cog,
  input  logic             nres,
  hub_slot_sched_if.master hub
);

  typedef enum logic {ST_PRE, ST_RUN} state_t;

  localparam logic [1:0] PH_LAST  = 2'(SLOT_CYCLES - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUMCOGS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_phase;
  logic [3:0]         r_slot_idx;
  logic [NUMCOGS-1:0] r_bus_sel;
  logic               r_wrap;

  logic               w_adv;
  logic [1:0]         w_phase_nxt;
  logic [15:0]        w_ena_pad;
  logic               w_found;
  logic [3:0]         w_nxt_idx;
  logic [15:0]        w_sel_pad;
  logic               w_wrap_nxt;

  assign w_adv       = (r_phase == PH_LAST);
  assign w_phase_nxt = w_adv ? 2'd0 : r_phase + 2'd1;

  always_comb begin
    w_ena_pad              = '0;
    w_ena_pad[NUMCOGS-1:0] = hub.cog_ena;
  end

  // Reset leaves slot_idx at the last cog, so "search from slot_idx+1"
  // naturally starts at cog 0 for the first selection.
  always_comb begin
    logic [5:0] w_sum;
    w_found   = 1'b0;
    w_nxt_idx = r_slot_idx;
    w_sum     = '0;
    if (!hub.skip_idle) begin
      w_found   = 1'b1;
      w_nxt_idx = (r_slot_idx == IDX_LAST) ? 4'd0 : r_slot_idx + 4'd1;
    end else begin
      // Scan farthest-first so the nearest enabled cog is the last to win.
      for (int k = NUMCOGS; k >= 1; k--) begin
        w_sum = 6'(r_slot_idx) + 6'(k);
        if (w_sum >= 6'(NUMCOGS)) begin
          w_sum = w_sum - 6'(NUMCOGS);
        end
        if (w_ena_pad[w_sum[3:0]]) begin
          w_found   = 1'b1;
          w_nxt_idx = w_sum[3:0];
        end
      end
    end
  end

  always_comb begin
    w_sel_pad            = '0;
    w_sel_pad[w_nxt_idx] = 1'b1;
  end

  // ST_PRE means no cog has owned a slot since reset, which masks the wrap
  // marker on the first real selection; idle slots do not leave ST_PRE.
  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (w_adv && w_found) begin
      w_state_nxt = ST_RUN;
      w_wrap_nxt  = (r_state == ST_RUN) && (w_nxt_idx <= r_slot_idx);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      r_state <= ST_PRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      r_phase    <= 2'd0;
      r_slot_idx <= IDX_LAST;
      r_bus_sel  <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_adv) begin
        if (w_found) begin
          r_bus_sel  <= w_sel_pad[NUMCOGS-1:0];
          r_slot_idx <= w_nxt_idx;
        end else begin
          r_bus_sel  <= '0;
        end
      end
    end
  end

  assign hub.ena_bus    = w_adv;
  assign hub.slot_start = (r_phase == 2'd0);
  assign hub.bus_sel    = r_bus_sel;
  assign hub.slot_idx   = r_slot_idx;
  assign hub.slot_valid = |r_bus_sel;
  assign hub.wrap       = r_wrap;

endmodule

// File: tb/tb_hub_slot_sched.sv
// Bench for hub_slot_sched: directed scenarios on an 8x2 and a 3x4 instance,
// plus randomized mode/enable traffic against a slot-level reference model.
module tb_hub_slot_sched;

  localparam int NA  = 8;
  localparam int SCA = 2;
  localparam int NB  = 3;
  localparam int SCB = 4;

  logic clk;
  logic nres_a;
  logic nres_b;
  int   n_checks;
  int   n_fail;

  hub_slot_sched_if #(.NUMCOGS(NA)) ifa ();
  hub_slot_sched_if #(.NUMCOGS(NB)) ifb ();

  hub_slot_sched #(.NUMCOGS(NA), .SLOT_CYCLES(SCA)) dut_a (
    .clk_cog (clk),
    .nres    (nres_a),
    .hub     (ifa)
  );

  hub_slot_sched #(.NUMCOGS(NB), .SLOT_CYCLES(SCB)) dut_b (
    .clk_cog (clk),
    .nres    (nres_b),
    .hub     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs_a;
  logic [10:0] obs_b;
  assign obs_a = {ifa.ena_bus, ifa.slot_start, ifa.slot_valid, ifa.wrap, ifa.slot_idx, ifa.bus_sel};
  assign obs_b = {ifb.ena_bus, ifb.slot_start, ifb.slot_valid, ifb.wrap, ifb.slot_idx, ifb.bus_sel};

  // Expected observation vectors; sel is an owner index, -1 meaning no owner.
  function automatic logic [15:0] exp_a(logic ena, logic st, logic wr, int idx, int sel);
    logic [7:0] s;
    s = (sel >= 0) ? 8'(1 << sel) : 8'h00;
    return {ena, st, (sel >= 0), wr, 4'(idx), s};
  endfunction

  function automatic logic [10:0] exp_b(logic ena, logic st, logic wr, int idx, int sel);
    logic [2:0] s;
    s = (sel >= 0) ? 3'(1 << sel) : 3'b000;
    return {ena, st, (sel >= 0), wr, 4'(idx), s};
  endfunction

  // Reference model for instance A: slot owner chosen from the rules directly.
  function automatic int pick(int last, logic [NA-1:0] ena, logic skip);
    if (!skip) return (last + 1) % NA;
    for (int k = 1; k <= NA; k++) begin
      if (ena[(last + k) % NA]) return (last + k) % NA;
    end
    return -1;
  endfunction

  int m_ph;
  int m_last;
  int m_sel;
  bit m_has;
  bit m_wrap;

  always @(posedge clk or negedge nres_a) begin
    if (!nres_a) begin
      m_ph   <= 0;
      m_last <= NA - 1;
      m_sel  <= -1;
      m_has  <= 1'b0;
      m_wrap <= 1'b0;
    end else begin
      m_ph   <= (m_ph + 1) % SCA;
      m_wrap <= 1'b0;
      if (m_ph == SCA - 1) begin
        if (pick(m_last, ifa.cog_ena, ifa.skip_idle) >= 0) begin
          m_sel  <= pick(m_last, ifa.cog_ena, ifa.skip_idle);
          m_last <= pick(m_last, ifa.cog_ena, ifa.skip_idle);
          m_has  <= 1'b1;
          m_wrap <= m_has && (pick(m_last, ifa.cog_ena, ifa.skip_idle) <= m_last);
        end else begin
          m_sel  <= -1;
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (obs_a !== exp_a(1'b0, 1'b1, 1'b0, NA - 1, -1)) begin
      n_fail++;
      $display("FAIL reset_a: got %h expected %h", obs_a, exp_a(1'b0, 1'b1, 1'b0, NA - 1, -1));
    end
    n_checks++;
    if (obs_b !== exp_b(1'b0, 1'b1, 1'b0, NB - 1, -1)) begin
      n_fail++;
      $display("FAIL reset_b: got %h expected %h", obs_b, exp_b(1'b0, 1'b1, 1'b0, NB - 1, -1));
    end
  endtask

  task automatic test_legacy();
    logic [15:0] e;
    int o;
    ifa.skip_idle = 1'b0;
    ifa.cog_ena   = 8'h00;
    @(negedge clk);
    nres_a = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      o = (c < 2) ? -1 : (c / 2 - 1) % 8;
      e = exp_a(1'((c % 2) == 1), 1'((c % 2) == 0), 1'(c == 18), (o < 0) ? 7 : o, o);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL legacy c=%0d: got %h expected %h", c, obs_a, e);
      end
      @(negedge clk);
    end
  endtask

  // Leaves the bench 1 time unit after the negedge of the second clock of the cog-5 slot.
  task automatic test_skip_two();
    logic [15:0] e;
    int own [5] = '{-1, 2, 5, 2, 5};
    nres_a = 1'b0;
    ifa.skip_idle = 1'b1;
    ifa.cog_ena   = 8'h24;
    @(negedge clk);
    nres_a = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      e = exp_a(1'((c % 2) == 1), 1'((c % 2) == 0), 1'(c == 6), (own[c / 2] < 0) ? 7 : own[c / 2], own[c / 2]);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL skip_two c=%0d: got %h expected %h", c, obs_a, e);
      end
      if (c < 9) @(negedge clk);
    end
  endtask

  task automatic test_empty();
    logic [15:0] e;
    int own [6] = '{-1, -1, 0, 0, 0, 0};
    ifa.cog_ena = 8'h00;
    for (int c = 10; c < 16; c++) begin
      @(negedge clk);
      #1;
      e = exp_a(1'((c % 2) == 1), 1'((c % 2) == 0), 1'(c == 12 || c == 14),
                (own[c - 10] < 0) ? 5 : 0, own[c - 10]);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL empty c=%0d: got %h expected %h", c, obs_a, e);
      end
      if (c == 11) ifa.cog_ena = 8'h01;
    end
  endtask

  task automatic test_mode_switch();
    logic [15:0] e;
    nres_a = 1'b0;
    ifa.skip_idle = 1'b0;
    ifa.cog_ena   = 8'h49;
    @(negedge clk);
    nres_a = 1'b1;
    repeat (8) @(negedge clk);
    for (int c = 8; c < 14; c++) begin
      #1;
      if (c < 10)      e = exp_a(1'(c == 9), 1'(c == 8), 1'b0, 3, 3);
      else if (c < 12) e = exp_a(1'(c == 11), 1'(c == 10), 1'b0, 6, 6);
      else             e = exp_a(1'(c == 13), 1'(c == 12), 1'(c == 12), 0, 0);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL mode_switch c=%0d: got %h expected %h", c, obs_a, e);
      end
      if (c == 8) begin
        ifa.skip_idle = 1'b1;
        ifa.cog_ena   = 8'h41;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    nres_a = 1'b0;
    ifa.skip_idle = 1'b0;
    ifa.cog_ena   = 8'h00;
    @(negedge clk);
    nres_a = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (obs_a !== exp_a(1'b0, 1'b1, 1'b0, 4, 4)) begin
      n_fail++;
      $display("FAIL async_pre: got %h expected %h", obs_a, exp_a(1'b0, 1'b1, 1'b0, 4, 4));
    end
    #1 nres_a = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== exp_a(1'b0, 1'b1, 1'b0, NA - 1, -1)) begin
      n_fail++;
      $display("FAIL async_hit: got %h expected %h", obs_a, exp_a(1'b0, 1'b1, 1'b0, NA - 1, -1));
    end
    #1 nres_a = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      #1;
      e = (c == 1) ? exp_a(1'b1, 1'b0, 1'b0, NA - 1, -1) : exp_a(1'(c == 3), 1'(c == 2), 1'b0, 0, 0);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL async_restart c=%0d: got %h expected %h", c, obs_a, e);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      #1;
      e = exp_a(1'(m_ph == SCA - 1), 1'(m_ph == 0), m_wrap, m_last, m_sel);
      n_checks++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h expected %h", c, obs_a, e);
      end
      if ($urandom_range(0, 15) == 0) ifa.skip_idle = ~ifa.skip_idle;
      if ($urandom_range(0, 3) == 0) begin
        ifa.cog_ena = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 nres_a = 1'b0;
        #1 nres_a = 1'b1;
      end
    end
  endtask

  task automatic test_generic();
    logic [10:0] e;
    int o;
    ifb.skip_idle = 1'b0;
    ifb.cog_ena   = 3'b000;
    @(negedge clk);
    nres_b = 1'b1;
    for (int c = 0; c < 22; c++) begin
      #1;
      o = (c < 4) ? -1 : (c / 4 - 1) % 3;
      e = exp_b(1'((c % 4) == 3), 1'((c % 4) == 0), 1'(c == 16), (o < 0) ? 2 : o, o);
      n_checks++;
      if (obs_b !== e) begin
        n_fail++;
        $display("FAIL generic c=%0d: got %h expected %h", c, obs_b, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    nres_a        = 1'b0;
    nres_b        = 1'b0;
    ifa.skip_idle = 1'b0;
    ifa.cog_ena   = '0;
    ifb.skip_idle = 1'b0;
    ifb.cog_ena   = '0;
    test_reset();
    test_legacy();
    test_skip_two();
    test_empty();
    test_mode_switch();
    test_async_reset();
    test_random();
    test_generic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub_slot_sched.md
# hub_slot_sched

Parametrised hub time-slot scheduler for the digital core. It generates the hub bus enable strobe and the one-hot cog select that give each cog its exclusive hub window. It generalises the fixed 8-cog, 2-cycle rotation to `NUMCOGS` slots of `SLOT_CYCLES` cycles each, and adds an optional mode that skips disabled cogs. It sits beside the hub and drives the `ena_bus`/`bus_sel` inputs of the hub and of every cog instance.

## Interface
- `NUMCOGS`, default 8: number of cog slots, legal range 1..15.
- `SLOT_CYCLES`, default 2: clocks per slot, legal range 1..4. A value of 2 gives the legacy timing.

- `clk_cog`, in, 1: cog clock. This is the only clock.
- `nres`, in, 1: reset, asynchronous, active-low.
- `skip_idle`, in, 1: mode select. 0 gives fixed rotation; 1 gives slots only to cogs whose `cog_ena` bit is set.
- `cog_ena`, in, NUMCOGS: per-cog running flags from the hub.
- `ena_bus`, out, 1: high on the last clock of each slot. The selection advances on the rising edge that ends that clock.
- `bus_sel`, out, NUMCOGS: one-hot select of the cog owning the current slot; all zeros when no cog owns it.
- `slot_idx`, out, 4: binary index of the current or last owner.
- `slot_valid`, out, 1: equals `|bus_sel`.
- `slot_start`, out, 1: high on the first clock of every slot.
- `wrap`, out, 1: one-clock pulse on the first clock of a slot whose owner index is ≤ the previous owner index.

## Operation
- **Phase counter.** `phase` runs 0..SLOT_CYCLES-1 and wraps to 0.
  - `ena_bus` = (phase == SLOT_CYCLES-1).
  - `slot_start` = (phase == 0).
  - With SLOT_CYCLES=1, `ena_bus` and `slot_start` are both held high.
- **Advance event.** A rising edge of `clk_cog` while `ena_bus`=1. At each advance event, `skip_idle` and `cog_ena` are sampled, the next owner is computed, and `bus_sel`, `slot_idx` and `wrap` are registered.
- **Fixed mode (`skip_idle`=0).**
  - Next owner = (slot_idx+1) mod NUMCOGS.
  - The first advance after reset selects cog 0.
  - `cog_ena` is ignored.
- **Skip mode (`skip_idle`=1).**
  - Next owner = first index i with `cog_ena[i]`=1, searching cyclically from slot_idx+1.
  - The first advance after reset searches from index 0.
  - If no bit is set: `bus_sel`=0, `slot_valid`=0, `slot_idx` holds its value.
  - A later search continues from the held `slot_idx`+1.
- **Wrap flag.**
  - `wrap`=1 when the new owner index ≤ the previous owner index. This includes a single enabled cog re-selecting itself.
  - The first selection after reset never asserts `wrap`.
  - An idle (zero) slot never asserts `wrap` and does not update the "previous owner" reference.
- **Mid-slot changes.**
  - A mode change mid-slot takes effect at the next advance event.
  - A cog disabled mid-slot keeps its slot to the end.

## Timing
- Reset values, applied immediately while `nres`=0:
  - `phase`=0, `ena_bus`=0 (or 1 when SLOT_CYCLES=1), `slot_start`=1.
  - `bus_sel`=0, `slot_valid`=0, `slot_idx`=NUMCOGS-1, `wrap`=0.
- After `nres` releases, the first slot (SLOT_CYCLES clocks) is a pre-slot with `bus_sel`=0. Its end is the first advance event.
- Owner latency:
  - A new owner is visible one clock after the advance edge.
  - `cog_ena` changes affect the slot after the next advance event (latency of one slot plus at most SLOT_CYCLES-1 clocks).
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Assertion of `nres` mid-slot aborts the slot immediately. The sequence restarts with a pre-slot.

## Test plan
- **Legacy rotation.** NUMCOGS=8, SLOT_CYCLES=2, skip_idle=0; release `nres` at cycle 0.
  - `ena_bus` reads 0,1,0,1…
  - `bus_sel`=0x00 on cycles 0–1, 0x01 on cycles 2–3, 0x02 on cycles 4–5, …, 0x80 on cycles 16–17, 0x01 with `wrap`=1 on cycle 18.
- **Skip mode, two cogs.** skip_idle=1, `cog_ena`=0x24.
  - Owner sequence is 0x04, 0x20, 0x04 (`wrap`=1 on the second 0x04), …
  - `slot_idx` reads 2, 5, 2.
- **Empty enable set.** skip_idle=1, `cog_ena` goes from 0x24 to 0x00 during the cog-5 slot.
  - Next slot: `bus_sel`=0, `slot_valid`=0, `slot_idx`=5.
  - `ena_bus` keeps toggling.
  - After `cog_ena` is set to 0x01, the first owner is 0x01 with `wrap`=1.
- **Generic width and depth.** NUMCOGS=3, SLOT_CYCLES=4.
  - `ena_bus` is high for 1 of every 4 clocks.
  - Owners rotate 1, 2, 4, 1, each for exactly 4 clocks, with `slot_start` on each slot's first clock.
- **Mode switch and late disable.** skip_idle goes 0→1 mid-slot of cog 3 with `cog_ena`=0x41, and cog 3's bit clears mid-slot.
  - Cog 3 finishes its slot.
  - Next owner is cog 6.
- **Async reset mid-slot.** Pulse `nres` low for half a clock during the cog-4 slot.
  - All outputs reach their reset values without a clock edge.
  - The restart begins with a 2-clock pre-slot, then cog 0.
